// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Holds the HI/LO registers and raises busy_out while an operation is in flight.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [1:0]            op_in,
    input  logic [DATA_WIDTH-1:0] RegRsData_in,
    input  logic [DATA_WIDTH-1:0] RegRtData_in,
    input  logic                  flush_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
    state_t r_state, w_next;

    logic [1:0]    r_op;
    logic [W-1:0]  r_a, r_b, r_rs_raw, r_hi, r_lo;
    logic [2*W-1:0] r_acc;
    logic          r_neg_q, r_neg_r, r_busy, r_done;
    logic [CW-1:0] r_cnt;

    // op_in[0] selects signed, op_in[1] selects divide
    logic         w_signed, w_rs_neg, w_rt_neg;
    logic [W-1:0] w_rs_abs, w_rt_abs;
    assign w_signed = op_in[0];
    assign w_rs_neg = w_signed & RegRsData_in[W-1];
    assign w_rt_neg = w_signed & RegRtData_in[W-1];
    assign w_rs_abs = w_rs_neg ? (W'(0) - RegRsData_in) : RegRsData_in;
    assign w_rt_abs = w_rt_neg ? (W'(0) - RegRtData_in) : RegRtData_in;

    // Shift-add: multiplier sits in the low half and drains out to the right
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_acc;
    assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    assign w_mul_acc = {w_mul_sum, r_acc[W-1:1]};

    // Restoring divide: remainder in the high half, quotient bits enter at bit 0
    logic [W+1:0]   w_div_diff;
    logic [2*W-1:0] w_div_acc;
    assign w_div_diff = {1'b0, r_acc[2*W-1:W-1]} - {2'b00, r_b};
    assign w_div_acc  = w_div_diff[W+1] ? {r_acc[2*W-2:0], 1'b0}
                                        : {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo, w_rem;
    assign w_prod = r_neg_q ? ((2*W)'(0) - r_acc) : r_acc;
    assign w_quo  = r_neg_q ? (W'(0) - r_acc[W-1:0]) : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? (W'(0) - r_acc[2*W-1:W]) : r_acc[2*W-1:W];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start_in && !flush_in) w_next = S_RUN;
            S_RUN:    if (flush_in) w_next = S_IDLE;
                      else if (r_cnt == CW'(W-1)) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rs_raw <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start_in && !flush_in) begin
                    r_op     <= op_in;
                    r_a      <= w_rs_abs;
                    r_b      <= w_rt_abs;
                    r_rs_raw <= RegRsData_in;
                    r_acc    <= {{W{1'b0}}, (op_in[1] ? w_rs_abs : w_rt_abs)};
                    r_neg_q  <= w_rs_neg ^ w_rt_neg;
                    r_neg_r  <= w_rs_neg;
                    r_cnt    <= '0;
                end
                S_RUN: begin
                    r_acc <= r_op[1] ? w_div_acc : w_mul_acc;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FINISH: if (!flush_in) begin
                    r_done <= 1'b1;
                    if (!r_op[1]) begin
                        r_hi <= w_prod[2*W-1:W];
                        r_lo <= w_prod[W-1:0];
                    end else if (r_b == '0) begin
                        r_hi <= r_rs_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out = r_busy;
    assign done_out = r_done;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: table of operations plus flush,
// ignored-start and async-reset sequences.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_in = 1'b0;
    logic [1:0]  op_in = 2'b00;
    logic [31:0] RegRsData_in = '0;
    logic [31:0] RegRtData_in = '0;
    logic        flush_in = 1'b0;
    logic        busy_out, done_out;
    logic [31:0] hi_out, lo_out;

    localparam logic [1:0] MULTU = 2'd0, MULT = 2'd1, DIVU = 2'd2, DIV = 2'd3;

    ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .op_in(op_in),
        .RegRsData_in(RegRsData_in), .RegRtData_in(RegRtData_in),
        .flush_in(flush_in), .busy_out(busy_out), .done_out(done_out),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue at E0, count edges to done_out, check latency, busy, result, pulse width
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo);
        int cyc;
        op_in = op; RegRsData_in = rs; RegRtData_in = rt; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk({name, " busy@E0+"}, 32'(busy_out), 32'd1);
        cyc = 0;
        while (!done_out && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd33);
        chk({name, " hi"}, hi_out, hi);
        chk({name, " lo"}, lo_out, lo);
        chk({name, " busy@E33+"}, 32'(busy_out), 32'd0);
        tick();
        chk({name, " done pulse"}, 32'(done_out), 32'd0);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[9]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
        vecs[12] = '{MULTU, 32'd3,        32'd4,        32'h00000000, 32'h0000000C};

        #12;
        chk("reset busy", 32'(busy_out), 32'd0);
        chk("reset done", 32'(done_out), 32'd0);
        chk("reset hi", hi_out, 32'd0);
        chk("reset lo", lo_out, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].hi, vecs[i].lo);

        // Flush: HI=0/LO=0xC left by the last vector must survive
        op_in = DIVU; RegRsData_in = 32'd100; RegRtData_in = 32'd7; start_in = 1'b1;
        tick();                              // E0
        start_in = 1'b0;
        for (int e = 1; e <= 10; e++) tick(); // E10
        flush_in = 1'b1;
        tick();                              // E11
        flush_in = 1'b0;
        chk("flush busy", 32'(busy_out), 32'd0);
        chk("flush done", 32'(done_out), 32'd0);
        chk("flush hi", hi_out, 32'd0);
        chk("flush lo", lo_out, 32'h0000000C);
        begin
            int seen = 0;
            for (int e = 0; e < 40; e++) begin
                tick();
                if (done_out) seen++;
            end
            chk("flush no late done", 32'(seen), 32'd0);
        end

        // Second start while busy is ignored
        op_in = MULTU; RegRsData_in = 32'd2; RegRtData_in = 32'd3; start_in = 1'b1;
        tick();                              // E0
        start_in = 1'b0;
        for (int e = 1; e <= 4; e++) tick(); // E4
        op_in = DIVU; RegRsData_in = 32'd9; RegRtData_in = 32'd9; start_in = 1'b1;
        tick();                              // E5
        start_in = 1'b0;
        begin
            int cyc = 5;
            while (!done_out && cyc < 45) begin
                tick();
                cyc++;
            end
            chk("ignore latency", 32'(cyc), 32'd33);
        end
        chk("ignore hi", hi_out, 32'd0);
        chk("ignore lo", lo_out, 32'd6);
        tick();
        chk("ignore no 2nd op", 32'(busy_out), 32'd0);

        // Asynchronous reset mid-divide
        op_in = DIVU; RegRsData_in = 32'd100; RegRtData_in = 32'd7; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        #2 rst = 1'b0;
        #1;
        chk("async rst busy", 32'(busy_out), 32'd0);
        chk("async rst done", 32'(done_out), 32'd0);
        chk("async rst hi", hi_out, 32'd0);
        chk("async rst lo", lo_out, 32'd0);
        #3 rst = 1'b1;
        tick();
        run_op("post-reset 7*6", MULTU, 32'd7, 32'd6, 32'd0, 32'h0000002A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, fed directly by the ID-EX pipeline register outputs (Rs/Rt operand data plus a decoded mul/div operation).
- Computes MULT, MULTU, DIV and DIVU over 32 radix-2 iterations.
- Holds the results in architectural HI/LO registers.
- Asserts busy_out so the hazard/stall logic can freeze the IF/ID and ID/EX registers while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
start_in  input  1  one-cycle request to begin an operation; sampled only in IDLE.
op_in  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
RegRsData_in  input  32  multiplicand / dividend.
RegRtData_in  input  32  multiplier / divisor.
flush_in  input  1  abort the in-flight operation (branch/exception squash).
busy_out  output  1  operation in flight; the stall request.
done_out  output  1  one-cycle pulse: HI/LO just updated.
hi_out  output  32  HI register (product high word / remainder).
lo_out  output  32  LO register (product low word / quotient).

Behaviour:
- Reset: async on rst low. State=IDLE, busy_out=0, done_out=0, hi_out=0, lo_out=0, internal counter and working registers=0. Reset mid-operation discards the operation with no HI/LO update.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On a rising edge with start_in=1 and flush_in=0, latch op_in and the operands.
  - For signed ops, latch the absolute values and record the result signs: product sign = Rs[31]^Rt[31]; quotient sign likewise; remainder sign = Rs[31].
  - Counter=0; go to RUN.
- RUN:
  - One iteration per clock.
  - Multiply is shift-add over a 64-bit accumulator.
  - Divide is restoring shift-subtract, producing quotient and remainder.
  - Counter increments each edge. After the 32nd iteration edge (counter reaches DATA_WIDTH-1 then wraps), go to FINISH.
- FINISH: one edge.
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - Write HI/LO; go to IDLE.
  - done_out=1 for exactly the following cycle.
- Latency: the start edge is E0; the iterations are E1..E32; HI/LO update at E33. busy_out is registered: 1 from after E0 through E33, 0 after E33. busy_out=1 in RUN and FINISH.
- start_in while busy: ignored; no queueing.
- flush_in=1 in RUN or FINISH:
  - Next edge goes to IDLE with HI/LO unchanged and no done_out pulse.
  - flush_in has priority over start_in and over the FINISH write.
- Divide by zero:
  - Both DIVU and DIV complete in normal latency.
  - LO=0xFFFFFFFF, HI=Rs unchanged (raw dividend, no sign correction on HI).
- DIV overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Width rules:
  - Multiply results are the full 64-bit product, split HI[63:32] / LO[31:0].
  - Signed magnitude of 0x80000000 is handled as unsigned 0x80000000 (no overflow in the 32-bit magnitude).
- hi_out/lo_out are held constant between FINISH writes.
- done_out and the HI/LO update occur on the same edge.

Test Plan:
- MULTU Rs=0xFFFFFFFF, Rt=0x00000002, start at E0 -> busy_out=1 from E0+ through E33; at E33 HI=0x00000001, LO=0xFFFFFFFE; done_out=1 for one cycle; busy_out=0.
- MULT Rs=0xFFFFFFFD (-3), Rt=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; signed DIV Rs=0xFFFFFFF9 (-7), Rt=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Boundary values:
  - DIVU Rs=0x12345678, Rt=0 -> LO=0xFFFFFFFF, HI=0x12345678 after 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Load HI/LO via MULTU 3*4 (HI=0, LO=0xC). Start DIVU 100/7; assert flush_in at E10 -> IDLE at E11, busy_out=0, no done_out, HI=0, LO=0xC retained.
- Start MULTU 2*3; pulse start_in again at E5 with different operands -> second request ignored; result HI=0, LO=6 at E33.
- Assert rst low asynchronously at E20 of a DIVU -> all outputs 0 immediately. Release, then run MULTU 7*6 -> LO=0x2A after 33 cycles.
